// File: rtl/vxe_axi4slv_rd_burst.sv
// AXI4 slave read-path BIU: splits FIXED/INCR/WRAP bursts into single-beat BIU reads, buffers beats in an R FIFO.
// Latency: AR handshake in N -> biu_renable in N+1 -> RVALID in N+2 when the beat is accepted in N+1; 1 beat/cycle sustained.
// Backpressure: RREADY low fills the R FIFO; biu_renable drops while it is full, and ARREADY stays low until the burst is fully pushed.
//
// Ports:
//   S_AXI4_ACLK / S_AXI4_ARESET : clock, asynchronous active-high reset
//   S_AXI4_AR*                  : read address channel (ID, ADDR, LEN, BURST, VALID/READY)
//   S_AXI4_R*                   : read data channel fed from the head of the R FIFO
//   biu_raddr/biu_renable       : per-beat read request, held until biu_raccept
//   biu_rdata/biu_raccept/biu_rerror : BIU reply, data and error qualified by biu_raccept
module vxe_axi4slv_rd_burst #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  S_AXI4_ACLK,
  input  logic                  S_AXI4_ARESET,
  input  logic [ID_WIDTH-1:0]   S_AXI4_ARID,
  input  logic [ADDR_WIDTH-1:0] S_AXI4_ARADDR,
  input  logic [7:0]            S_AXI4_ARLEN,
  input  logic [1:0]            S_AXI4_ARBURST,
  input  logic                  S_AXI4_ARVALID,
  output logic                  S_AXI4_ARREADY,
  output logic [ID_WIDTH-1:0]   S_AXI4_RID,
  output logic [DATA_WIDTH-1:0] S_AXI4_RDATA,
  output logic [1:0]            S_AXI4_RRESP,
  output logic                  S_AXI4_RLAST,
  output logic                  S_AXI4_RVALID,
  input  logic                  S_AXI4_RREADY,
  output logic [ADDR_WIDTH-1:0] biu_raddr,
  output logic                  biu_renable,
  input  logic [DATA_WIDTH-1:0] biu_rdata,
  input  logic                  biu_raccept,
  input  logic                  biu_rerror
);

  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int BSHIFT = $clog2(BYTES);
  localparam int PW     = $clog2(FIFO_DEPTH);
  localparam int EW     = ID_WIDTH + DATA_WIDTH + 3;

  typedef enum logic [1:0] {IDLE, BURST, ERRB} state_t;

  state_t                state_q, state_d;
  logic                  arready_q, arready_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [1:0]            burst_q, burst_d;
  logic [7:0]            beat_q, beat_d;

  logic [EW-1:0]         mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]           count_q, count_d;

  logic                  fifo_full, fifo_empty, push_vld, pop;
  logic [EW-1:0]         push_dat;
  logic                  beat_last, ar_legal;
  logic [ADDR_WIDTH-1:0] wrap_mask, addr_inc, addr_next;

  assign fifo_full  = (count_q == (PW+1)'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign pop        = !fifo_empty && S_AXI4_RREADY;
  assign beat_last  = (beat_q == len_q);

  // ARREADY is a flop so that it reads 0 during reset and the first cycle after it.
  assign S_AXI4_ARREADY = arready_q;
  assign biu_renable    = (state_q == BURST) && !fifo_full;
  assign biu_raddr      = addr_q & ~ADDR_WIDTH'(BYTES - 1);
  assign S_AXI4_RVALID  = !fifo_empty;
  assign {S_AXI4_RID, S_AXI4_RDATA, S_AXI4_RRESP, S_AXI4_RLAST} = mem_q[rd_ptr_q];

  // WRAP is only legal for 2/4/8/16 beats; reserved burst type is always an error.
  assign ar_legal = (S_AXI4_ARBURST != 2'b11) &&
                    !((S_AXI4_ARBURST == 2'b10) &&
                      !((S_AXI4_ARLEN == 8'd1) || (S_AXI4_ARLEN == 8'd3) ||
                        (S_AXI4_ARLEN == 8'd7) || (S_AXI4_ARLEN == 8'd15)));

  // Wrap window is the total burst size in bytes; only the bits inside it advance.
  assign wrap_mask = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << BSHIFT) - ADDR_WIDTH'(1);
  assign addr_inc  = addr_q + ADDR_WIDTH'(BYTES);

  always_comb begin
    addr_next = addr_inc;
    case (burst_q)
      2'b00:   addr_next = addr_q;
      2'b10:   addr_next = (addr_q & ~wrap_mask) | (addr_inc & wrap_mask);
      default: addr_next = addr_inc;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    addr_d   = addr_q;
    len_d    = len_q;
    burst_d  = burst_q;
    beat_d   = beat_q;
    push_vld = 1'b0;
    push_dat = '0;
    case (state_q)
      IDLE: begin
        if (S_AXI4_ARVALID && arready_q) begin
          id_d    = S_AXI4_ARID;
          addr_d  = S_AXI4_ARADDR;
          len_d   = S_AXI4_ARLEN;
          burst_d = S_AXI4_ARBURST;
          beat_d  = 8'd0;
          state_d = ar_legal ? BURST : ERRB;
        end
      end
      BURST: begin
        if (biu_renable && biu_raccept) begin
          push_vld = 1'b1;
          push_dat = {id_q, biu_rdata, (biu_rerror ? 2'b10 : 2'b00), beat_last};
          addr_d   = addr_next;
          beat_d   = beat_q + 8'd1;
          if (beat_last) state_d = IDLE;
        end
      end
      ERRB: begin
        // Synthesised SLVERR beats, paced only by FIFO space.
        if (!fifo_full) begin
          push_vld = 1'b1;
          push_dat = {id_q, {DATA_WIDTH{1'b0}}, 2'b10, beat_last};
          beat_d   = beat_q + 8'd1;
          if (beat_last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    arready_d = (state_d == IDLE);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_vld) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)      rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_vld, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge S_AXI4_ACLK or posedge S_AXI4_ARESET) begin
    if (S_AXI4_ARESET) begin
      state_q   <= IDLE;
      arready_q <= 1'b0;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      burst_q   <= '0;
      beat_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      arready_q <= arready_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      burst_q   <= burst_d;
      beat_q    <= beat_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // Storage is cleared on reset so the R outputs read 0 out of reset.
  always_ff @(posedge S_AXI4_ACLK or posedge S_AXI4_ARESET) begin
    if (S_AXI4_ARESET) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (push_vld) begin
      mem_q[wr_ptr_q] <= push_dat;
    end
  end

endmodule

// File: tb/tb_vxe_axi4slv_rd_burst.sv
// Bench for vxe_axi4slv_rd_burst: directed scenarios plus randomized bursts.
// Outputs are compared every cycle against a burst-level reference model.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_vxe_axi4slv_rd_burst;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  ARID = '0;
  logic [31:0] ARADDR = '0;
  logic [7:0]  ARLEN = '0;
  logic [1:0]  ARBURST = '0;
  logic        ARVALID = 1'b0;
  logic        S_AXI4_ARREADY;
  logic [7:0]  S_AXI4_RID;
  logic [31:0] S_AXI4_RDATA;
  logic [1:0]  S_AXI4_RRESP;
  logic        S_AXI4_RLAST, S_AXI4_RVALID;
  logic        S_AXI4_RREADY;
  logic [31:0] biu_raddr, biu_rdata;
  logic        biu_renable, biu_raccept, biu_rerror;

  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  beat_t       exp_r[$];
  beat_t       r_log[$];
  logic [31:0] acc_log[$];
  logic [31:0] m_addr[$];

  int total = 0, bad = 0, cyc = 0;
  bit m_busy = 0, m_err = 0, post_rst = 0, rv_wait = 0;
  logic [7:0] m_id = '0, m_len = '0;
  int m_beat = 0;
  int acc_cnt = 0, acc_in_burst = 0, hs_cyc = 0, last_acc_cyc = 0, first_rv_cyc = 0;
  int acc_mode = 0, rr_mode = 0, err_beat = -2;

  always #5 clk = ~clk;

  vxe_axi4slv_rd_burst #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(8), .FIFO_DEPTH(DEPTH)) dut (
    .S_AXI4_ACLK(clk), .S_AXI4_ARESET(rst),
    .S_AXI4_ARID(ARID), .S_AXI4_ARADDR(ARADDR), .S_AXI4_ARLEN(ARLEN),
    .S_AXI4_ARBURST(ARBURST), .S_AXI4_ARVALID(ARVALID), .S_AXI4_ARREADY(S_AXI4_ARREADY),
    .S_AXI4_RID(S_AXI4_RID), .S_AXI4_RDATA(S_AXI4_RDATA), .S_AXI4_RRESP(S_AXI4_RRESP),
    .S_AXI4_RLAST(S_AXI4_RLAST), .S_AXI4_RVALID(S_AXI4_RVALID), .S_AXI4_RREADY(S_AXI4_RREADY),
    .biu_raddr(biu_raddr), .biu_renable(biu_renable), .biu_rdata(biu_rdata),
    .biu_raccept(biu_raccept), .biu_rerror(biu_rerror)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: every beat address of a burst from plain arithmetic.
  task automatic m_start(input logic [7:0] id, input logic [31:0] a, input logic [7:0] len, input logic [1:0] bt);
    logic [31:0] sz, base, x;
    m_busy = 1; m_id = id; m_len = len; m_beat = 0;
    m_addr.delete();
    m_err = (bt == 2'b11) || (bt == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15));
    if (!m_err) begin
      for (int i = 0; i <= int'(len); i++) begin
        case (bt)
          2'b00: x = a;
          2'b01: x = a + 32'(i * 4);
          default: begin
            sz   = 32'((int'(len) + 1) * 4);
            base = a - (a % sz);
            x    = base + (((a - base) + 32'(i * 4)) % sz);
          end
        endcase
        m_addr.push_back(x);
      end
    end
  endtask

  // Compare process: one pass per cycle on the falling edge.
  initial begin
    forever begin
      bit e_ar, e_ren, e_rv, do_push;
      beat_t nb;
      @(negedge clk);
      cyc++;
      if (rst) begin
        chk("rst_arready", S_AXI4_ARREADY, 0);
        chk("rst_renable", biu_renable, 0);
        chk("rst_rvalid", S_AXI4_RVALID, 0);
        exp_r.delete(); m_addr.delete();
        m_busy = 0; post_rst = 1; rv_wait = 0;
      end else begin
        e_ar  = !m_busy && !post_rst;
        e_ren = m_busy && !m_err && (exp_r.size() < DEPTH);
        e_rv  = exp_r.size() > 0;
        chk("arready", S_AXI4_ARREADY, e_ar);
        chk("renable", biu_renable, e_ren);
        chk("rvalid", S_AXI4_RVALID, e_rv);
        if (e_ren && biu_renable && m_addr.size() > 0)
          chk("raddr", biu_raddr, m_addr[0] & 32'hFFFF_FFFC);
        if (e_rv && S_AXI4_RVALID)
          chk("rbeat", {S_AXI4_RID, S_AXI4_RDATA, S_AXI4_RRESP, S_AXI4_RLAST}, exp_r[0]);
        if (S_AXI4_RVALID && S_AXI4_RREADY)
          r_log.push_back(beat_t'({S_AXI4_RID, S_AXI4_RDATA, S_AXI4_RRESP, S_AXI4_RLAST}));
        if (rv_wait && S_AXI4_RVALID) begin first_rv_cyc = cyc; rv_wait = 0; end
        if (biu_renable && biu_raccept) begin
          acc_cnt++; acc_in_burst++; last_acc_cyc = cyc;
          acc_log.push_back(biu_raddr);
        end
        do_push = 0;
        if (m_busy && exp_r.size() < DEPTH && (m_err || biu_raccept)) begin
          do_push = 1;
          nb.id   = m_id;
          nb.data = m_err ? 32'h0 : biu_rdata;
          nb.resp = (m_err || biu_rerror) ? 2'b10 : 2'b00;
          nb.last = (m_beat == int'(m_len));
          m_beat++;
          if (!m_err) void'(m_addr.pop_front());
          if (nb.last) m_busy = 0;
        end
        if (e_rv && S_AXI4_RREADY) void'(exp_r.pop_front());
        if (do_push) exp_r.push_back(nb);
        if (e_ar && ARVALID) begin
          m_start(ARID, ARADDR, ARLEN, ARBURST);
          hs_cyc = cyc; acc_in_burst = 0; rv_wait = 1;
        end
        post_rst = 0;
      end
    end
  end

  // BIU and R-channel responder.
  initial begin
    biu_raccept = 0; biu_rdata = '0; biu_rerror = 0; S_AXI4_RREADY = 0;
    forever begin
      @(posedge clk); #1;
      biu_raccept   = (acc_mode == 0) ? 1'b1 : (acc_mode == 1) ? ($urandom % 10 < 7) : 1'b0;
      biu_rdata     = $urandom;
      biu_rerror    = (err_beat == -1) ? ($urandom % 6 == 0) : (acc_in_burst == err_beat);
      S_AXI4_RREADY = (rr_mode == 0) ? 1'b1 : (rr_mode == 1) ? ($urandom % 10 < 7) : 1'b0;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_ar(input logic [7:0] id, input logic [31:0] a, input logic [7:0] len, input logic [1:0] bt);
    int n = 0;
    bit done = 0;
    ARID = id; ARADDR = a; ARLEN = len; ARBURST = bt; ARVALID = 1;
    while (!done) begin
      @(negedge clk);
      if (S_AXI4_ARREADY) done = 1;
      else if (++n > 3000) begin
        total++; bad++;
        $display("FAIL ar_timeout: got no ARREADY want ARREADY within 3000 cycles");
        done = 1;
      end
    end
    @(posedge clk); #1;
    ARVALID = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((m_busy || exp_r.size() != 0) && n < 5000) begin cycles(1); n++; end
    if (n >= 5000) begin
      total++; bad++;
      $display("FAIL idle_timeout: got busy want idle within 5000 cycles");
    end
    cycles(1);
  endtask

  initial begin
    int b0, r0, a0, hs, n, rl0, acc0;
    logic [31:0] raddr0, lit[8];
    logic [7:0] len;
    logic [1:0] bt;

    cycles(3);
    rst = 0;
    cycles(2);

    // 1: INCR 4 beats, latency and RLAST placement
    b0 = acc_log.size(); r0 = r_log.size();
    send_ar(8'h5A, 32'h1000, 8'd3, 2'b01);
    hs = hs_cyc;
    wait_idle();
    lit = '{32'h1000, 32'h1004, 32'h1008, 32'h100C, 0, 0, 0, 0};
    for (int i = 0; i < 4; i++) chk("t1_addr", acc_log[b0+i], lit[i]);
    for (int i = 0; i < 4; i++) chk("t1_beat", {r_log[r0+i].id, r_log[r0+i].resp, r_log[r0+i].last}, {8'h5A, 2'b00, (i == 3)});
    chk("t1_latency", first_rv_cyc - hs, 2);

    // 2: WRAP 8 beats, then FIXED 3 beats
    b0 = acc_log.size();
    send_ar(8'h01, 32'h2018, 8'd7, 2'b10);
    wait_idle();
    lit = '{32'h2018, 32'h201C, 32'h2000, 32'h2004, 32'h2008, 32'h200C, 32'h2010, 32'h2014};
    for (int i = 0; i < 8; i++) chk("t2_wrap", acc_log[b0+i], lit[i]);
    b0 = acc_log.size();
    send_ar(8'h02, 32'h30, 8'd2, 2'b00);
    wait_idle();
    for (int i = 0; i < 3; i++) chk("t2_fixed", acc_log[b0+i], 32'h30);

    // 3: RREADY low fills the FIFO, then drains 16 beats
    rr_mode = 2; cycles(1);
    r0 = r_log.size(); a0 = acc_cnt;
    send_ar(8'h33, 32'h4000, 8'd15, 2'b01);
    cycles(20);
    chk("t3_accepts", acc_cnt - a0, DEPTH);
    chk("t3_renable_off", biu_renable, 0);
    rr_mode = 0;
    wait_idle();
    chk("t3_count", r_log.size() - r0, 16);
    for (int i = 0; i < 16; i++) chk("t3_beat", {r_log[r0+i].id, r_log[r0+i].last}, {8'h33, (i == 15)});

    // 4: beat error on beat 2; reserved and illegal-WRAP bursts
    err_beat = 1; r0 = r_log.size();
    send_ar(8'h44, 32'h500, 8'd3, 2'b01);
    wait_idle();
    err_beat = -2;
    lit = '{0, 2, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 4; i++) chk("t4_resp", r_log[r0+i].resp, lit[i]);
    r0 = r_log.size(); a0 = acc_cnt;
    send_ar(8'h45, 32'h600, 8'd3, 2'b11);
    wait_idle();
    chk("t4_rsv_count", r_log.size() - r0, 4);
    for (int i = 0; i < 4; i++) chk("t4_rsv_beat", r_log[r0+i], {8'h45, 32'h0, 2'b10, (i == 3)});
    r0 = r_log.size();
    send_ar(8'h46, 32'h700, 8'd2, 2'b10);
    wait_idle();
    chk("t4_wrap2_count", r_log.size() - r0, 3);
    for (int i = 0; i < 3; i++) chk("t4_wrap2_beat", r_log[r0+i], {8'h46, 32'h0, 2'b10, (i == 2)});
    chk("t4_no_accepts", acc_cnt - a0, 0);

    // 5: BIU stall mid-burst, then reset mid-burst
    send_ar(8'h50, 32'h800, 8'd7, 2'b01);
    n = 0;
    while (acc_in_burst < 2 && n < 100) begin cycles(1); n++; end
    acc_mode = 2;
    cycles(3);
    raddr0 = biu_raddr; acc0 = acc_cnt; rl0 = r_log.size();
    for (int i = 0; i < 5; i++) begin
      cycles(1);
      chk("t5_raddr_hold", biu_raddr, raddr0);
      chk("t5_arready", S_AXI4_ARREADY, 0);
      chk("t5_no_accept", acc_cnt, acc0);
    end
    chk("t5_no_rbeat", r_log.size(), rl0);
    rr_mode = 2; acc_mode = 0;
    cycles(3);
    rst = 1;
    #1;
    chk("t5_rst_rvalid", S_AXI4_RVALID, 0);
    chk("t5_rst_arready", S_AXI4_ARREADY, 0);
    chk("t5_rst_renable", biu_renable, 0);
    cycles(2);
    rst = 0; rr_mode = 0;
    cycles(2);
    r0 = r_log.size();
    send_ar(8'h66, 32'h900, 8'd0, 2'b01);
    wait_idle();
    chk("t5_after_count", r_log.size() - r0, 1);
    chk("t5_after_beat", {r_log[r0].id, r_log[r0].resp, r_log[r0].last}, {8'h66, 2'b00, 1'b1});

    // 6: second AR held during a burst
    send_ar(8'h11, 32'hA00, 8'd3, 2'b01);
    send_ar(8'h22, 32'hB00, 8'd1, 2'b01);
    chk("t6_hs_gap", hs_cyc - last_acc_cyc, 1);
    wait_idle();
    n = r_log.size();
    chk("t6_a_last", {r_log[n-3].id, r_log[n-3].last}, {8'h11, 1'b1});
    chk("t6_b_first", {r_log[n-2].id, r_log[n-2].last}, {8'h22, 1'b0});

    // Randomized bursts with random BIU acceptance, errors and RREADY
    acc_mode = 1; rr_mode = 1; err_beat = -1;
    for (int k = 0; k < 40; k++) begin
      bt = 2'($urandom % 4);
      if (bt == 2'b10) begin
        lit = '{32'd1, 32'd3, 32'd7, 32'd15, 32'd0, 32'd2, 32'd5, 32'd1};
        len = 8'(lit[$urandom % 8]);
      end else begin
        len = ($urandom % 10 == 0) ? 8'($urandom) : 8'($urandom % 10);
      end
      send_ar(8'($urandom), $urandom, len, bt);
      if ($urandom % 2 == 0) wait_idle();
    end
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vxe_axi4slv_rd_burst.md
Name:
vxe_axi4slv_rd_burst

Overview:
- Parameterised AXI4 slave read-path BIU with full burst support (FIXED/INCR/WRAP, ARLEN up to 255).
- Breaks each burst into single-beat BIU reads and buffers responses in an R-channel FIFO, so the BIU keeps issuing while the master stalls RREADY.
- Sits between the AXI4 interconnect and a block's register/memory BIU.
- Is the read-side successor of the single-beat slave BIU.

Parameters:
ADDR_WIDTH, 32, address width; also the BIU address width.
DATA_WIDTH, 32, data width; must be 32 or 64. BYTES = DATA_WIDTH/8.
ID_WIDTH, 8, AXI ID width.
FIFO_DEPTH, 4, R FIFO entries; must be a power of two and at least 2.

Ports:
S_AXI4_ACLK  in  1  clock
S_AXI4_ARESET  in  1  asynchronous reset, active-high
S_AXI4_ARID  in  ID_WIDTH  read ID
S_AXI4_ARADDR  in  ADDR_WIDTH  burst start address
S_AXI4_ARLEN  in  8  beats minus 1
S_AXI4_ARBURST  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
S_AXI4_ARVALID  in  1  address valid
S_AXI4_ARREADY  out  1  address ready
S_AXI4_RID  out  ID_WIDTH  response ID
S_AXI4_RDATA  out  DATA_WIDTH  read data
S_AXI4_RRESP  out  2  OKAY=00, SLVERR=10
S_AXI4_RLAST  out  1  final beat of burst
S_AXI4_RVALID  out  1  read data valid
S_AXI4_RREADY  in  1  master ready
biu_raddr  out  ADDR_WIDTH  beat address; low log2(BYTES) bits always 0
biu_renable  out  1  beat read request
biu_rdata  in  DATA_WIDTH  data; valid in the cycle biu_raccept is high
biu_raccept  in  1  BIU accepted the beat and returned data
biu_rerror  in  1  beat error; qualified by biu_raccept

Behaviour:
- Reset values: all outputs 0, including ARREADY. FSM goes to IDLE and the FIFO is emptied.
- Reset mid-burst discards the burst and all buffered beats. There is no partial completion.
- The FSM has three states: IDLE, BURST and ERRB.
- IDLE:
  - ARREADY=1.
  - On ARVALID&&ARREADY: latch ID, ARADDR, ARLEN and ARBURST; clear the beat counter.
  - Next state is BURST if the request is legal, otherwise ERRB.
  - A request is illegal when ARBURST=11, or ARBURST=10 with ARLEN not in {1,3,7,15}.
- BURST:
  - ARREADY=0.
  - biu_renable = ~fifo_full, using the registered full flag.
  - biu_raddr = current address with the low bits masked.
  - On biu_renable&&biu_raccept, push {ID, biu_rdata, biu_rerror?SLVERR:OKAY, last} into the FIFO, then advance the address and the beat counter.
  - biu_raddr and biu_renable are held stable until accepted.
- ERRB:
  - biu_renable=0.
  - Push one {ID, 0, SLVERR, last} per cycle while the FIFO is not full, ARLEN+1 beats in total.
- last = (beat counter == latched ARLEN). After the last push, return to IDLE; ARREADY is high the next cycle.
- Address advance:
  - FIXED: address unchanged.
  - INCR: addr + BYTES, modulo 2^ADDR_WIDTH. There is no 4 KB boundary check.
  - WRAP: mask = (ARLEN+1)*BYTES - 1; next = (addr & ~mask) | ((addr + BYTES) & mask).
- R FIFO:
  - RVALID = ~empty. RID, RDATA, RRESP and RLAST come straight from the head entry and are stable while RVALID && ~RREADY.
  - Pop on RVALID&&RREADY.
  - Push and pop in the same cycle are both performed and the count is unchanged.
  - A push is never attempted when full. A pop that frees a full FIFO enables biu_renable the following cycle.
- Latency: AR handshake in cycle N -> biu_renable in N+1 -> with raccept in N+1, RVALID in N+2.
- Sustained rate is 1 beat/cycle with raccept and RREADY held high.
- ARLEN=0 gives a single-beat burst with RLAST=1.
- Bursts are serviced strictly in order; no second AR is accepted until the current burst is fully pushed.

Test Plan:
1. INCR, ARADDR=0x1000, ARLEN=3, ARID=0x5A, DATA_WIDTH=32, raccept=1, RREADY=1 -> biu_raddr 0x1000/04/08/0C; 4 R beats with RID=0x5A, RRESP=00, RLAST only on beat 4; first RVALID 2 cycles after the AR handshake.
2. WRAP, ARADDR=0x2018, ARLEN=7 -> addresses 0x2018, 1C, 00, 04, 08, 0C, 10, 14. Then FIXED, ARADDR=0x30, ARLEN=2 -> 0x30 three times.
3. INCR, ARLEN=15, RREADY=0 -> exactly FIFO_DEPTH (4) BIU accepts, then biu_renable=0. Release RREADY -> all 16 beats delivered in order, with no loss or duplication.
4. biu_rerror=1 on beat 2 of an ARLEN=3 burst -> beat 2 RRESP=10, other beats 00. ARBURST=11 or WRAP with ARLEN=2 -> 4 or 3 SLVERR beats with RDATA=0, biu_renable never asserted.
5. biu_raccept low for 5 cycles mid-burst -> biu_raddr stable, ARREADY=0, no R beat produced. Then assert S_AXI4_ARESET mid-burst -> RVALID=0, ARREADY=0, biu_renable=0 immediately. After release, a new ARLEN=0 burst completes normally.
6. ARVALID held during a burst -> ARREADY=0 until the last beat is pushed. The second burst starts the cycle after ARREADY returns, and its RID follows the first burst's RLAST beat.
